// File: rtl/rv32i_trace_pkg.sv
// Shared encodings and record layout for the rv32i post-trigger trace buffer.
// The record width grows by a 32-bit timestamp when TRACE_TIMESTAMP_EN is defined.
package rv32i_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_POST    = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam logic [1:0] MODE_ALL       = 2'd0;
    localparam logic [1:0] MODE_MEM       = 2'd1;
    localparam logic [1:0] MODE_BR        = 2'd2;
    localparam logic [1:0] MODE_MEM_OR_BR = 2'd3;

    localparam int TS_W = 32;
`ifdef TRACE_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    // Record layout, LSB first: branch, mem_write, write_data, alu_result, instr, pc, [timestamp]
    localparam int OFF_BRANCH     = 0;
    localparam int OFF_MEM_WRITE  = 1;
    localparam int OFF_WRITE_DATA = 2;

    function automatic int off_alu(input int xlen);
        return 2 + xlen;
    endfunction

    function automatic int off_instr(input int xlen);
        return 2 + 2 * xlen;
    endfunction

    function automatic int off_pc(input int xlen);
        return 2 + 3 * xlen;
    endfunction

    function automatic int off_ts(input int xlen);
        return 2 + 4 * xlen;
    endfunction

    function automatic int rec_width(input int xlen);
        return 4 * xlen + 2 + (TS_EN ? TS_W : 0);
    endfunction

endpackage

// File: rtl/rv32i_trace_buffer_if.sv
// Retire-record input and valid/ready readout port of the trace buffer.
interface rv32i_trace_buffer_if #(
    parameter int XLEN = 32
);
    import rv32i_trace_pkg::*;

    localparam int RW = rec_width(XLEN);

    logic            en;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] write_data;
    logic            mem_write;
    logic            branch;
    logic            rd_valid;
    logic            rd_ready;
    logic [RW-1:0]   rd_data;

    modport master (
        output en, pc, instr, alu_result, write_data, mem_write, branch, rd_ready,
        input  rd_valid, rd_data
    );

    modport slave (
        input  en, pc, instr, alu_result, write_data, mem_write, branch, rd_ready,
        output rd_valid, rd_data
    );

endinterface

// File: rtl/rv32i_trace_buffer_ram.sv
// Trace record storage: synchronous write, asynchronous read, storage is not reset.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 130
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem_r [DEPTH];

    // Record write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/rv32i_trace_buffer.sv
// Post-trigger instruction trace buffer: filtered circular capture, PC trigger, oldest-first readout.
// Optional TRACE_TIMESTAMP_EN adds a free-running 32-bit cycle stamp to each record.
module rv32i_trace_buffer
    import rv32i_trace_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int POST  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    rv32i_trace_buffer_if.slave    bus,
    input  logic [1:0]             mode,
    input  logic [XLEN-1:0]        trig_pc,
    input  logic                   arm,
    output logic [$clog2(DEPTH):0] count,
    output logic [1:0]             state,
    output logic                   overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = rec_width(XLEN);

    state_e          state_r;
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW-1:0]   post_cnt_r;
    logic [CW-1:0]   count_r;
    logic            overflow_r;

    logic            filt_s;
    logic            trig_hit_s;
    logic            push_s;
    logic            pop_s;
    logic            full_s;
    logic            rd_valid_s;
    logic [RW-1:0]   wr_data_s;
    logic [RW-1:0]   rd_raw_s;

    // Mode filter on the retire flags
    always_comb begin
        filt_s = 1'b0;
        case (mode)
            MODE_ALL:       filt_s = 1'b1;
            MODE_MEM:       filt_s = bus.mem_write;
            MODE_BR:        filt_s = bus.branch;
            MODE_MEM_OR_BR: filt_s = bus.mem_write | bus.branch;
            default:        filt_s = 1'b0;
        endcase
    end

    // The trigger record bypasses the filter; arm suppresses any push or pop in its cycle
    assign trig_hit_s = (state_r == ST_CAPTURE) && bus.en && (bus.pc == trig_pc);
    assign push_s     = !arm && bus.en &&
                        (((state_r == ST_CAPTURE) && (filt_s || trig_hit_s)) ||
                         ((state_r == ST_POST) && filt_s));
    assign full_s     = (count_r == CW'(DEPTH));
    assign rd_valid_s = (state_r == ST_DONE) && (count_r != {CW{1'b0}});
    assign pop_s      = !arm && rd_valid_s && bus.rd_ready;

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_r;

    // Free-running cycle counter stamped into each record
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts_r <= {TS_W{1'b0}};
        end else begin
            ts_r <= ts_r + TS_W'(1);
        end
    end

    assign wr_data_s = {ts_r, bus.pc, bus.instr, bus.alu_result, bus.write_data,
                        bus.mem_write, bus.branch};
`else
    assign wr_data_s = {bus.pc, bus.instr, bus.alu_result, bus.write_data,
                        bus.mem_write, bus.branch};
`endif

    // Capture/readout FSM with pointers, occupancy, post counter and sticky overflow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            post_cnt_r <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            overflow_r <= 1'b0;
        end else if (arm) begin
            state_r    <= ST_CAPTURE;
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            post_cnt_r <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
                if (full_s) begin
                    rd_ptr_r   <= rd_ptr_r + AW'(1);
                    overflow_r <= 1'b1;
                end else begin
                    count_r <= count_r + CW'(1);
                end
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
                count_r  <= count_r - CW'(1);
            end
            case (state_r)
                ST_IDLE: state_r <= ST_IDLE;
                ST_CAPTURE: begin
                    if (trig_hit_s) begin
                        post_cnt_r <= AW'(POST);
                        state_r    <= (POST == 0) ? ST_DONE : ST_POST;
                    end
                end
                ST_POST: begin
                    if (push_s) begin
                        post_cnt_r <= post_cnt_r - AW'(1);
                        if (post_cnt_r == AW'(1)) begin
                            state_r <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if ((count_r == {CW{1'b0}}) || (pop_s && (count_r == CW'(1)))) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (RW)
    ) u_ram (
        .clk   (clk),
        .we    (push_s),
        .waddr (wr_ptr_r),
        .wdata (wr_data_s),
        .raddr (rd_ptr_r),
        .rdata (rd_raw_s)
    );

    assign bus.rd_valid = rd_valid_s;
    assign bus.rd_data  = rd_valid_s ? rd_raw_s : {RW{1'b0}};
    assign count        = count_r;
    assign state        = state_r;
    assign overflow     = overflow_r;

endmodule

// File: tb/tb_rv32i_trace_buffer.sv
// Self-checking bench for rv32i_trace_buffer: three instances (POST=8,1,0) share one retire stream.
module tb_rv32i_trace_buffer;
    import rv32i_trace_pkg::*;

    localparam int XLEN = 32;
    localparam int RW   = rec_width(XLEN);
    localparam int BW   = 4 * XLEN + 2;
    localparam int PCO  = off_pc(XLEN);
    localparam int NI   = 3;

    function automatic int post_of(input int i);
        return (i == 0) ? 8 : ((i == 1) ? 1 : 0);
    endfunction

    logic            clk;
    logic            reset;
    logic            en;
    logic [XLEN-1:0] pc, instr, alu_result, write_data;
    logic            mem_write, branch, rd_ready;
    logic [1:0]      mode;
    logic [XLEN-1:0] trig_pc;
    logic            arm;

    logic            vld [NI];
    logic [RW-1:0]   rdd [NI];
    logic [4:0]      cnt [NI];
    logic [1:0]      st  [NI];
    logic            ovf [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        rv32i_trace_buffer_if #(.XLEN(XLEN)) bus ();
        assign bus.en         = en;
        assign bus.pc         = pc;
        assign bus.instr      = instr;
        assign bus.alu_result = alu_result;
        assign bus.write_data = write_data;
        assign bus.mem_write  = mem_write;
        assign bus.branch     = branch;
        assign bus.rd_ready   = rd_ready;
        assign vld[g]         = bus.rd_valid;
        assign rdd[g]         = bus.rd_data;

        rv32i_trace_buffer #(.XLEN(XLEN), .DEPTH(16), .POST(post_of(g))) dut (
            .clk      (clk),
            .reset    (reset),
            .bus      (bus),
            .mode     (mode),
            .trig_pc  (trig_pc),
            .arm      (arm),
            .count    (cnt[g]),
            .state    (st[g]),
            .overflow (ovf[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Scoreboard: expected records of the active instance, oldest first
    logic [BW-1:0] m_q [$];
    int            m_st;
    int            m_post;
    int            m_inst;

    typedef struct {
        int          inst;
        logic [1:0]  mode;
        logic [31:0] trig;
        int          n;
        logic [31:0] mw_mask;
        logic [31:0] br_mask;
        int          exp_cnt;
        logic        exp_ovf;
        logic [31:0] exp_first;
    } vec_t;
    vec_t vt [5];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] rec_of(input logic [31:0] p, input logic mw, input logic br);
        return {p, p ^ 32'hA5A5_0000, p + 32'd100, ~p, mw, br};
    endfunction

    task automatic do_arm(input int inst);
        m_inst = inst;
        m_q.delete();
        m_st = 1;
        arm = 1'b1; en = 1'b1; pc = trig_pc; mem_write = 1'b1; branch = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0; en = 1'b0;
        check("arm_count", cnt[inst], 5'd0);
        check("arm_ovf", ovf[inst], 1'b0);
        check("arm_state", st[inst], 2'd1);
    endtask

    task automatic retire(input logic [31:0] p, input logic mw, input logic br);
        logic q, hit;
        en = 1'b1; pc = p; instr = p ^ 32'hA5A5_0000; alu_result = p + 32'd100;
        write_data = ~p; mem_write = mw; branch = br;
        q   = (mode == 2'd0) || (mode == 2'd1 && mw) || (mode == 2'd2 && br) ||
              (mode == 2'd3 && (mw || br));
        hit = (m_st == 1) && (p == trig_pc);
        if ((m_st == 1 && (q || hit)) || (m_st == 2 && q)) begin
            m_q.push_back(rec_of(p, mw, br));
            if (m_q.size() > 16) void'(m_q.pop_front());
        end
        if (hit) begin
            m_post = post_of(m_inst);
            m_st   = (m_post == 0) ? 3 : 2;
        end else if (m_st == 2 && q) begin
            m_post--;
            if (m_post == 0) m_st = 3;
        end
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        logic [BW-1:0] e;
        if (m_q.size() == 0) begin
            total++; bad++;
            $display("FAIL %s_underrun: got %0d records expected more", tag, m_q.size());
        end else begin
            e = m_q.pop_front();
            check({tag, "_valid"}, vld[m_inst], 1'b1);
            check({tag, "_data"}, rdd[m_inst][BW-1:0], e);
        end
        rd_ready = 1'b1;
        @(posedge clk); #1;
        rd_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test done");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; en = 1'b0; pc = 32'd0; instr = 32'd0; alu_result = 32'd0;
        write_data = 32'd0; mem_write = 1'b0; branch = 1'b0; rd_ready = 1'b0;
        mode = 2'd0; trig_pc = 32'd0; arm = 1'b0;
        #12;
        check("rst_state", st[0], 2'd0);
        check("rst_count", cnt[0], 5'd0);
        check("rst_ovf", ovf[0], 1'b0);
        check("rst_valid", vld[0], 1'b0);
        check("rst_data", rdd[0], {RW{1'b0}});
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        vt[0] = '{0, 2'd0, 32'h20, 17, 32'h0,  32'h0,        16, 1'b1, 32'h04};
        vt[1] = '{1, 2'd1, 32'h0C, 7,  32'h14, 32'h0,        3,  1'b0, 32'h08};
        vt[2] = '{2, 2'd0, 32'h14, 6,  32'h0,  32'h0,        6,  1'b0, 32'h00};
        vt[3] = '{0, 2'd2, 32'h10, 24, 32'h0,  32'hAAAAAAAA, 11, 1'b0, 32'h04};
        vt[4] = '{1, 2'd3, 32'h0C, 8,  32'h02, 32'h40,       3,  1'b0, 32'h04};

        for (int v = 0; v < 5; v++) begin
            mode    = vt[v].mode;
            trig_pc = vt[v].trig;
            do_arm(vt[v].inst);
            for (int i = 0; i < vt[v].n; i++) begin
                retire(32'(i * 4), vt[v].mw_mask[i], vt[v].br_mask[i]);
            end
            check($sformatf("v%0d_state", v), st[m_inst], 2'd3);
            check($sformatf("v%0d_count", v), cnt[m_inst], vt[v].exp_cnt[4:0]);
            check($sformatf("v%0d_ovf", v), ovf[m_inst], vt[v].exp_ovf);
            check($sformatf("v%0d_first", v), rdd[m_inst][PCO +: 32], vt[v].exp_first);
            for (int k = 0; k < vt[v].exp_cnt; k++) begin
                pop_check($sformatf("v%0d_rd%0d", v, k));
            end
            check($sformatf("v%0d_end_valid", v), vld[m_inst], 1'b0);
            check($sformatf("v%0d_end_state", v), st[m_inst], 2'd0);
        end

        // Backpressure in DONE, then re-arm from DONE, then async reset mid-capture
        mode = 2'd0; trig_pc = 32'h1C;
        do_arm(2);
        for (int i = 0; i < 8; i++) retire(32'(i * 4), 1'b0, 1'b0);
        check("bp_state", st[2], 2'd3);
        for (int c = 0; c < 5; c++) begin
            check("bp_hold_data", rdd[2][BW-1:0], m_q[0]);
            check("bp_hold_count", cnt[2], 5'd8);
            @(posedge clk); #1;
        end
        for (int k = 0; k < 3; k++) pop_check($sformatf("bp_rd%0d", k));
        check("bp_count5", cnt[2], 5'd5);
        check("bp_next", rdd[2][PCO +: 32], 32'h0C);
        do_arm(2);
        for (int i = 0; i < 3; i++) retire(32'h100 + 32'(i * 4), 1'b0, 1'b0);
        check("cap_count", cnt[2], 5'd3);
        #2 reset = 1'b0;
        #1;
        check("async_rst_state", st[2], 2'd0);
        check("async_rst_valid", vld[2], 1'b0);
        check("async_rst_count", cnt[2], 5'd0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

`ifdef TRACE_TIMESTAMP_EN
        begin
            logic [31:0] ts_prev;
            mode = 2'd0; trig_pc = 32'h0C;
            do_arm(2);
            for (int i = 0; i < 4; i++) retire(32'(i * 4), 1'b0, 1'b0);
            ts_prev = rdd[2][RW-1 -: 32];
            pop_check("ts_rd0");
            for (int k = 1; k < 4; k++) begin
                check($sformatf("ts_delta%0d", k), rdd[2][RW-1 -: 32] - ts_prev, 32'd1);
                ts_prev = rdd[2][RW-1 -: 32];
                pop_check($sformatf("ts_rd%0d", k));
            end
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
